wrr_grant_arbiter: RTL

Parametrised weighted round-robin arbiter, the next generation of the team's single-weight grant_request block.
- Keeps its own rotating pointer; no external next_grant mask.
- Takes a per-channel weight vector and a two-level priority class.
- Holds each grant for a weight-defined burst, with early release when the owner drops its request.
- Sits between requesting masters and a shared resource (bus or port).

---
 rtl/wrr_grant_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/wrr_grant_arbiter.sv
// Weighted round-robin arbiter with a two-level priority class.
// A winner holds its grant for a weight-defined burst. The grant is released
// early if the owner drops its request. Every burst is followed by exactly
// one idle arbitration cycle, and the rotating pointer then moves past the
// last owner.
module wrr_grant_arbiter #(
  parameter int CHANNELS   = 8,
  parameter int WEIGHT_W   = 5,
  parameter int MAX_WEIGHT = 16,
  localparam int ID_W      = (CHANNELS > 2) ? $clog2(CHANNELS) : 1,
  localparam int CNT_W     = $clog2(MAX_WEIGHT + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          request,
  input  logic [CHANNELS-1:0]          priorities,
  input  logic [CHANNELS*WEIGHT_W-1:0] weight,
  output logic [CHANNELS-1:0]          grant,
  output logic                         grant_valid,
  output logic [ID_W-1:0]              grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01
  } state_e;

  state_e               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     eff_q, eff_d;
  logic [CHANNELS-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic                 valid_q, valid_d;

  logic [CHANNELS-1:0]  cand;
  logic                 found;
  logic [ID_W-1:0]      win;
  logic [WEIGHT_W-1:0]  w_arr [CHANNELS];

  // A zero weight still gives a one-cycle burst, and oversized weights are
  // capped so that the burst counter cannot overflow.
  function automatic logic [CNT_W-1:0] clamp_weight(input logic [WEIGHT_W-1:0] w);
    if (w == '0)                  return CNT_W'(1);
    else if (int'(w) > MAX_WEIGHT) return CNT_W'(MAX_WEIGHT);
    else                           return CNT_W'(w);
  endfunction

  // Unpack the flat weight bus into one field per channel.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_arr[c] = weight[c*WEIGHT_W +: WEIGHT_W];
    end
  end

  // Candidate set and rotating first-set-bit search starting at ptr_q.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    cand  = request & priorities;
    found = 1'b0;
    win   = '0;
    if (cand == '0) cand = request;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!found && cand[ID_W'((int'(ptr_q) + i) % CHANNELS)]) begin
        found = 1'b1;
        win   = ID_W'((int'(ptr_q) + i) % CHANNELS);
      end
    end
  end

  // Next-state logic: arbitrate in IDLE, count out the burst in HOLD.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    eff_d   = eff_q;
    grant_d = grant_q;
    id_d    = id_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = CHANNELS'(1) << win;
          id_d    = win;
          valid_d = 1'b1;
          eff_d   = clamp_weight(w_arr[win]);
          count_d = CNT_W'(1);
          state_d = HOLD;
        end else begin
          grant_d = '0;
          id_d    = '0;
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        // Owner drop and burst expiry share one release path, so the pointer
        // advances only once even if both happen on the same edge.
        if (!request[id_q] || (count_q >= eff_q)) begin
          grant_d = '0;
          id_d    = '0;
          valid_d = 1'b0;
          state_d = IDLE;
          ptr_d   = (id_q == ID_W'(CHANNELS - 1)) ? '0 : id_q + 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        grant_d = '0;
        id_d    = '0;
        valid_d = 1'b0;
        count_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      eff_q   <= '0;
      grant_q <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: registers use non-blocking assignments so all of them update from the same pre-edge values.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      eff_q   <= eff_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      valid_q <= valid_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_id    = id_q;

endmodule
